// File: rtl/up_control.sv
// Instruction sequencer for the nibble-instruction microprocessor.
// Decodes FSM state, ir and z into datapath selects and write strobes.
module up_control (
  input  logic       clk,
  input  logic       nRst,
  input  logic [3:0] ir,
  input  logic       z,
  input  logic       hold,
  output logic [4:0] op,
  output logic       ir_we,
  output logic       pc_we,
  output logic [2:0] rb_sel_in,
  output logic       rb_we,
  output logic       sp_we,
  output logic       adr_we,
  output logic       mem_we,
  output logic       halted
);

  typedef enum logic [2:0] {
    FETCH_A, FETCH_D, EX0, EX1, EX2, EX3, HALT
  } state_t;

  localparam logic [3:0] OP_LD1  = 4'h5;
  localparam logic [3:0] OP_LD2  = 4'h6;
  localparam logic [3:0] OP_ST   = 4'h7;
  localparam logic [3:0] OP_CPY  = 4'h8;
  localparam logic [3:0] OP_HALT = 4'h9;
  localparam logic [3:0] OP_PUSH = 4'hA;
  localparam logic [3:0] OP_POP  = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_BEQ  = 4'hD;
  localparam logic [3:0] OP_CALL = 4'hE;
  localparam logic [3:0] OP_RET  = 4'hF;

  state_t state_q, state_d;
  logic ir_we_raw, pc_we_raw, rb_we_raw, sp_we_raw, adr_we_raw, mem_we_raw;

  // State register; hold freezes the sequence in place.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst)      state_q <= FETCH_A;
    else if (!hold) state_q <= state_d;
  end

  // Next state: instruction length depends on the opcode in ir.
  always_comb begin
    state_d = FETCH_A;
    case (state_q)
      FETCH_A: state_d = FETCH_D;
      FETCH_D: state_d = EX0;
      EX0: begin
        case (ir)
          OP_HALT:                                 state_d = HALT;
          OP_LD1, OP_LD2, OP_ST, OP_PUSH, OP_POP,
          OP_CALL, OP_RET:                         state_d = EX1;
          default:                                 state_d = FETCH_A;
        endcase
      end
      EX1:     state_d = (ir == OP_PUSH || ir == OP_POP || ir == OP_CALL || ir == OP_RET)
                         ? EX2 : FETCH_A;
      EX2:     state_d = (ir == OP_CALL) ? EX3 : FETCH_A;
      EX3:     state_d = FETCH_A;
      HALT:    state_d = HALT;
      default: state_d = FETCH_A;
    endcase
  end

  // Output decode, before the hold gating of the write enables.
  always_comb begin
    op         = 5'b11111;
    rb_sel_in  = 3'b000;
    ir_we_raw  = 1'b0;
    pc_we_raw  = 1'b0;
    rb_we_raw  = 1'b0;
    sp_we_raw  = 1'b0;
    adr_we_raw = 1'b0;
    mem_we_raw = 1'b0;
    case (state_q)
      FETCH_A: begin op = 5'b10100; adr_we_raw = 1'b1; end
      FETCH_D: begin op = 5'b10101; ir_we_raw = 1'b1; pc_we_raw = 1'b1; end
      EX0: begin
        case (ir)
          4'h1, 4'h2, 4'h3, 4'h4: begin
            op = {1'b0, ir - 4'd1}; rb_we_raw = 1'b1; rb_sel_in = 3'b111;
          end
          OP_LD1, OP_LD2, OP_ST: begin op = 5'b10110; adr_we_raw = 1'b1; end
          OP_CPY:  begin op = 5'b10110; rb_we_raw = 1'b1; rb_sel_in = 3'b101; end
          OP_PUSH, OP_CALL: begin op = 5'b11001; adr_we_raw = 1'b1; end
          OP_POP, OP_RET:   begin op = 5'b10111; sp_we_raw = 1'b1; end
          OP_JMP:  begin op = 5'b10110; pc_we_raw = 1'b1; end
          OP_BEQ: begin
            if (z) begin op = 5'b10110; pc_we_raw = 1'b1; end
          end
          default: ;
        endcase
      end
      EX1: begin
        case (ir)
          OP_LD1:  begin rb_we_raw = 1'b1; rb_sel_in = 3'b001; end
          OP_LD2:  begin rb_we_raw = 1'b1; rb_sel_in = 3'b010; end
          OP_ST, OP_PUSH: begin op = 5'b11100; mem_we_raw = 1'b1; end
          OP_POP, OP_RET: begin op = 5'b11001; adr_we_raw = 1'b1; end
          OP_CALL: begin op = 5'b11011; mem_we_raw = 1'b1; end
          default: ;
        endcase
      end
      EX2: begin
        case (ir)
          OP_PUSH, OP_CALL: begin op = 5'b11010; sp_we_raw = 1'b1; end
          OP_POP:  begin rb_we_raw = 1'b1; rb_sel_in = 3'b010; end
          OP_RET:  pc_we_raw = 1'b1;
          default: ;
        endcase
      end
      EX3: begin
        if (ir == OP_CALL) begin op = 5'b10110; pc_we_raw = 1'b1; end
      end
      default: ;
    endcase
  end

  assign ir_we  = ir_we_raw  & ~hold;
  assign pc_we  = pc_we_raw  & ~hold;
  assign rb_we  = rb_we_raw  & ~hold;
  assign sp_we  = sp_we_raw  & ~hold;
  assign adr_we = adr_we_raw & ~hold;
  assign mem_we = mem_we_raw & ~hold;
  assign halted = (state_q == HALT);

endmodule

// File: tb/tb_up_control.sv
// Randomized bench for up_control against a per-opcode micro-step table model.
module tb_up_control;

  logic       clk = 1'b0;
  logic       nRst, z, hold;
  logic [3:0] ir;
  logic [4:0] op;
  logic       ir_we, pc_we, rb_we, sp_we, adr_we, mem_we, halted;
  logic [2:0] rb_sel_in;

  up_control dut (
    .clk(clk), .nRst(nRst), .ir(ir), .z(z), .hold(hold),
    .op(op), .ir_we(ir_we), .pc_we(pc_we), .rb_sel_in(rb_sel_in), .rb_we(rb_we),
    .sp_we(sp_we), .adr_we(adr_we), .mem_we(mem_we), .halted(halted)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] EN_IR  = 6'b100000;
  localparam logic [5:0] EN_PC  = 6'b010000;
  localparam logic [5:0] EN_RB  = 6'b001000;
  localparam logic [5:0] EN_SP  = 6'b000100;
  localparam logic [5:0] EN_ADR = 6'b000010;
  localparam logic [5:0] EN_MEM = 6'b000001;

  int checks = 0;
  int failures = 0;
  int phase = 0;      // -1 halted, 0 fetch address, 1 fetch data, 2+k execute step k
  int cur_op = 0;
  int next_op = 0;
  int done = 0;
  int have_prev = 0;
  int cyc = 0;
  int mem_cnt = 0;
  int cpi_tab [16] = '{3, 3, 3, 3, 3, 4, 4, 4, 3, 3, 5, 5, 3, 3, 6, 5};

  logic [14:0] got;
  assign got = {halted, op, rb_sel_in, ir_we, pc_we, rb_we, sp_we, adr_we, mem_we};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [14:0] mk(input logic [4:0] o, input logic [2:0] s,
                                     input logic [5:0] en, input logic h);
    return {h, o, s, en};
  endfunction

  function automatic logic [14:0] ex_step(input int opc, input int k, input logic zz);
    logic [14:0] idle;
    idle = mk(5'b11111, 3'b000, 6'b0, 1'b0);
    case (opc)
      1, 2, 3, 4: return mk(5'(opc - 1), 3'b111, EN_RB, 1'b0);
      5, 6: return (k == 0) ? mk(5'b10110, 3'b000, EN_ADR, 1'b0)
                            : mk(5'b11111, (opc == 5) ? 3'b001 : 3'b010, EN_RB, 1'b0);
      7: return (k == 0) ? mk(5'b10110, 3'b000, EN_ADR, 1'b0)
                         : mk(5'b11100, 3'b000, EN_MEM, 1'b0);
      8: return mk(5'b10110, 3'b101, EN_RB, 1'b0);
      10: case (k)
            0: return mk(5'b11001, 3'b000, EN_ADR, 1'b0);
            1: return mk(5'b11100, 3'b000, EN_MEM, 1'b0);
            default: return mk(5'b11010, 3'b000, EN_SP, 1'b0);
          endcase
      11: case (k)
            0: return mk(5'b10111, 3'b000, EN_SP, 1'b0);
            1: return mk(5'b11001, 3'b000, EN_ADR, 1'b0);
            default: return mk(5'b11111, 3'b010, EN_RB, 1'b0);
          endcase
      12: return mk(5'b10110, 3'b000, EN_PC, 1'b0);
      13: return zz ? mk(5'b10110, 3'b000, EN_PC, 1'b0) : idle;
      14: case (k)
            0: return mk(5'b11001, 3'b000, EN_ADR, 1'b0);
            1: return mk(5'b11011, 3'b000, EN_MEM, 1'b0);
            2: return mk(5'b11010, 3'b000, EN_SP, 1'b0);
            default: return mk(5'b10110, 3'b000, EN_PC, 1'b0);
          endcase
      15: case (k)
            0: return mk(5'b10111, 3'b000, EN_SP, 1'b0);
            1: return mk(5'b11001, 3'b000, EN_ADR, 1'b0);
            default: return mk(5'b11111, 3'b000, EN_PC, 1'b0);
          endcase
      default: return idle;
    endcase
  endfunction

  function automatic logic [14:0] fa_vec();
    return mk(5'b10100, 3'b000, EN_ADR, 1'b0);
  endfunction

  function automatic logic [14:0] expected();
    case (phase)
      -1: return mk(5'b11111, 3'b000, 6'b0, 1'b1);
      0:  return fa_vec();
      1:  return mk(5'b10101, 3'b000, EN_IR | EN_PC, 1'b0);
      default: return ex_step(cur_op, phase - 2, z);
    endcase
  endfunction

  // One clock: drive at negedge, check outputs, advance the model; ends at next negedge.
  task automatic tick(input logic h);
    logic [14:0] e;
    hold = h;
    z = 1'($urandom);
    if (phase >= 2) ir = 4'(cur_op);
    else            ir = 4'($urandom_range(0, 15));
    #1;
    e = expected();
    if (h) e[5:0] = 6'b0;
    check("ctl", 32'(got), 32'(e));
    if (mem_we) mem_cnt++;
    if (!h) begin
      if (op == 5'b10100 && have_prev != 0) begin
        check("cpi", 32'(cyc), 32'(cpi_tab[cur_op]));
        cyc = 0;
      end
      cyc++;
      case (phase)
        -1: ;
        0: phase = 1;
        1: begin phase = 2; cur_op = next_op; have_prev = 1; end
        default: begin
          if (cur_op == 9) begin phase = -1; done = 1; end
          else if (phase - 2 == cpi_tab[cur_op] - 3) begin phase = 0; done = 1; end
          else phase++;
        end
      endcase
    end
    @(negedge clk);
  endtask

  task automatic run_instr(input int opc, input int hold_ex0, input int rand_hold,
                           input int stop_phase);
    int guard;
    int hold_left;
    logic h;
    guard = 0;
    hold_left = hold_ex0;
    done = 0;
    mem_cnt = 0;
    next_op = opc;
    while (done == 0 && guard < 200) begin
      if (stop_phase >= 0 && phase == stop_phase && cur_op == opc) break;
      if (phase == 2 && hold_left > 0) begin h = 1'b1; hold_left--; end
      else h = (rand_hold != 0) && ($urandom_range(0, 4) == 0);
      tick(h);
      guard++;
    end
    if (guard >= 200) check("timeout", 32'(done), 32'd1);
  endtask

  // Asynchronous reset asserted mid-cycle; called at a negedge.
  task automatic apply_reset();
    #2;
    hold = 1'b0;
    nRst = 1'b0;
    #1;
    check("rst_ctl", 32'(got), 32'(fa_vec()));
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_sp_we", 32'(sp_we), 32'd0);
    @(posedge clk);
    #1;
    check("rst_held", 32'(got), 32'(fa_vec()));
    @(negedge clk);
    nRst = 1'b1;
    phase = 0;
    have_prev = 0;
    cyc = 0;
  endtask

  initial begin
    int o;
    nRst = 1'b1;
    hold = 1'b0;
    ir = 4'h0;
    z = 1'b0;
    @(negedge clk);
    apply_reset();

    // Every non-halting opcode once without hold, then with random hold.
    for (int i = 0; i < 16; i++) if (i != 9) run_instr(i, 0, 0, -1);
    for (int i = 0; i < 16; i++) if (i != 9) run_instr(i, 0, 1, -1);

    // Random instruction stream with random hold.
    for (int i = 0; i < 300; i++) begin
      o = $urandom_range(0, 14);
      if (o >= 9) o++;
      run_instr(o, 0, 1, -1);
    end

    // Store delayed two cycles by hold in EX0 issues exactly one write.
    run_instr(7, 2, 0, -1);
    check("st_mem_we_count", 32'(mem_cnt), 32'd1);

    // Reset during CALL EX1 aborts the push.
    run_instr(14, 0, 0, 3);
    apply_reset();
    run_instr(0, 0, 0, -1);
    run_instr(14, 0, 0, -1);
    check("call_mem_we_count", 32'(mem_cnt), 32'd1);

    // HALT stays put with enables low until reset.
    run_instr(9, 0, 0, -1);
    check("halted", 32'(halted), 32'd1);
    for (int i = 0; i < 100; i++) tick(1'($urandom_range(0, 1)));
    apply_reset();
    check("halt_cleared", 32'(halted), 32'd0);
    for (int i = 0; i < 20; i++) begin
      o = $urandom_range(0, 14);
      if (o >= 9) o++;
      run_instr(o, 0, 1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
